// File: rtl/ipml_fifo_pkg.sv
// Shared constants and helpers for the ipml FIFO wrapper read-side logic.
// Read latency values mirror the FIFO output-register build option.
package ipml_fifo_pkg;

  localparam int RD_LAT_NOREG = 1;
  localparam int RD_LAT_OREG  = 2;

  // Occupancy counters only ever need to hold 0..3 (BUF_DEPTH is at most 3).
  localparam int CNT_W = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/ipml_fifo_rd_stream_if.sv
// First-word-fall-through valid/ready stream carrying words out of the FIFO read engine.
// The master drives valid/data; the slave drives ready.
interface ipml_fifo_rd_stream_if #(
  parameter int c_DATA_WIDTH = 8
);

  logic                    m_valid;
  logic [c_DATA_WIDTH-1:0] m_data;
  logic                    m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/ipml_fifo_rd_stream_skid_buf.sv
// Small circular register buffer that holds words returned by the FIFO until the consumer takes them.
// Depth need not be a power of two, so pointers wrap by explicit compare.
module ipml_fifo_skid_buf
  import ipml_fifo_pkg::*;
#(
  parameter int c_DATA_WIDTH = 8,
  parameter int c_DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [c_DATA_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic [CNT_W-1:0]        level,
  output logic [c_DATA_WIDTH-1:0] data
);

  localparam int PTR_W = clog2(c_DEPTH);

  logic [c_DATA_WIDTH-1:0] mem_q [c_DEPTH];
  logic [c_DATA_WIDTH-1:0] mem_d [c_DEPTH];
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        rptr_q, rptr_d;
  logic [CNT_W-1:0]        level_q, level_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(c_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave one undriven and infer a latch.
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + CNT_W'(1);
        2'b01:   level_d = level_q - CNT_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage is reset because m_data must read 0 out of reset; it is only a few flops.
      for (int i = 0; i < c_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign data  = mem_q[rptr_q];

endmodule

// File: rtl/ipml_fifo_rd_stream.sv
// FIFO read-side drain engine: issues rd_en, tracks words in flight through the RAM read latency
// and presents them from a skid buffer as a registered valid/ready stream.
module ipml_fifo_rd_stream
  import ipml_fifo_pkg::*;
#(
  parameter int c_DATA_WIDTH = 8,
  parameter int c_RD_LATENCY = RD_LAT_NOREG
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  output logic                         fifo_rd_en,
  output logic                         fifo_rd_oce,
  input  logic                         fifo_rd_empty,
  input  logic [c_DATA_WIDTH-1:0]      fifo_rd_data,
  input  logic                         flush,
  ipml_fifo_rd_stream_if.master        m,
  output logic [CNT_W-1:0]             buf_level
);

  localparam int BUF_DEPTH = c_RD_LATENCY + 1;
  localparam int OCC_W     = 3;

  logic [c_RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]        n_inflight;
  logic [OCC_W-1:0]        occupancy;
  logic                    pop;
  logic                    issue;
  logic                    capture;
  logic [c_DATA_WIDTH-1:0] buf_data;

  always_comb begin
    n_inflight = '0;
    for (int i = 0; i < c_RD_LATENCY; i++) begin
      n_inflight = n_inflight + CNT_W'(inflight_q[i]);
    end
  end

  assign pop = m.m_valid & m.m_ready;

  // Count a word against the buffer from the clock it is requested, so a stalled consumer can
  // never be handed more words than the buffer can hold.
  assign occupancy = OCC_W'(buf_level) + OCC_W'(n_inflight) - OCC_W'(pop);
  assign issue     = !fifo_rd_empty && !flush && (occupancy < OCC_W'(BUF_DEPTH));

  // A word arriving during a flush belongs to the discarded set.
  assign capture = inflight_q[c_RD_LATENCY-1] & ~flush;

  always_comb begin
    inflight_d = '0;
    if (!flush) begin
      inflight_d[0] = issue;
      for (int i = 1; i < c_RD_LATENCY; i++) begin
        inflight_d[i] = inflight_q[i-1];
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // The RAM clock enable shares rd_en, so it must be dead while reset is held.
  assign fifo_rd_en  = issue & ~rd_rst;
  assign fifo_rd_oce = 1'b1;

  ipml_fifo_skid_buf #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_DEPTH      (BUF_DEPTH)
  ) u_skid_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .flush     (flush),
    .push      (capture),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .level     (buf_level),
    .data      (buf_data)
  );

  assign m.m_valid = (buf_level != '0);
  assign m.m_data  = buf_data;

endmodule

// File: tb/tb_ipml_fifo_rd_stream.sv
// Directed bench for ipml_fifo_rd_stream: two DUTs (read latency 1 and 2), each fed by a
// behavioural FIFO model, exercised one after the other by the same scenario tasks.
module tb_ipml_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic [1:0] flush;
  logic [1:0] m_ready;
  logic [1:0] rd_en;
  logic [1:0] rd_oce;
  logic [1:0] rd_empty;
  logic [1:0] m_valid;
  logic [7:0] rd_data   [2];
  logic [7:0] m_data    [2];
  logic [1:0] buf_level [2];

  // Behavioural FIFO: linear store, never wraps within one run.
  logic [7:0] fmem   [2][4096];
  int         fwr    [2] = '{0, 0};
  int         frd    [2] = '{0, 0};
  int         viol   [2] = '{0, 0};
  logic [7:0] stage1 [2] = '{8'h00, 8'h00};
  logic [7:0] stage2 [2] = '{8'h00, 8'h00};

  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) begin
        if (fwr[i] == frd[i]) begin
          viol[i] <= viol[i] + 1;
        end else begin
          stage1[i] <= fmem[i][frd[i]];
          frd[i]    <= frd[i] + 1;
        end
      end
      stage2[i] <= stage1[i];
    end
  end

  assign rd_data[0] = stage1[0];
  assign rd_data[1] = stage2[1];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    ipml_fifo_rd_stream_if #(.c_DATA_WIDTH(8)) s_if ();

    assign s_if.m_ready = m_ready[g];
    assign m_valid[g]   = s_if.m_valid;
    assign m_data[g]    = s_if.m_data;
    assign rd_empty[g]  = (fwr[g] == frd[g]);

    ipml_fifo_rd_stream #(
      .c_DATA_WIDTH (8),
      .c_RD_LATENCY (g + 1)
    ) u_dut (
      .rd_clk        (clk),
      .rd_rst        (rst[g]),
      .fifo_rd_en    (rd_en[g]),
      .fifo_rd_oce   (rd_oce[g]),
      .fifo_rd_empty (rd_empty[g]),
      .fifo_rd_data  (rd_data[g]),
      .flush         (flush[g]),
      .m             (s_if.master),
      .buf_level     (buf_level[g])
    );
  end

  task automatic push_word(input int k, input logic [7:0] d);
    fmem[k][fwr[k]] = d;
    fwr[k] = fwr[k] + 1;
  endtask

  task automatic test_reset();
    int cnt [2];
    cnt = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) push_word(k, 8'hC3);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (m_valid[k] !== 1'b0) begin n_bad++; $display("FAIL rst_valid L=%0d: got %0b expected 0", k+1, m_valid[k]); end
      n_cmp++;
      if (m_data[k] !== 8'h00) begin n_bad++; $display("FAIL rst_data L=%0d: got %0h expected 00", k+1, m_data[k]); end
      n_cmp++;
      if (buf_level[k] !== 2'd0) begin n_bad++; $display("FAIL rst_level L=%0d: got %0d expected 0", k+1, buf_level[k]); end
      n_cmp++;
      if (rd_en[k] !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en L=%0d: got %0b expected 0", k+1, rd_en[k]); end
      n_cmp++;
      if (rd_oce[k] !== 1'b1) begin n_bad++; $display("FAIL rst_oce L=%0d: got %0b expected 1", k+1, rd_oce[k]); end
    end
    @(posedge clk); #1;
    rst     = 2'b00;
    m_ready = 2'b11;
    #1;
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_valid[k]) begin
          n_cmp++;
          if (m_data[k] !== 8'hC3) begin n_bad++; $display("FAIL rst_first_word L=%0d: got %0h expected c3", k+1, m_data[k]); end
          cnt[k]++;
        end
      end
      @(posedge clk); #2;
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (cnt[k] !== 1) begin n_bad++; $display("FAIL rst_word_count L=%0d: got %0d expected 1", k+1, cnt[k]); end
    end
    m_ready = 2'b00;
  endtask

  task automatic test_full_rate(input int k);
    int n_rd, first_rd, last_rd, rd_gaps, first_v, last_v, v_gaps, n_rx;
    logic [7:0] exp_d;
    n_rd = 0; first_rd = -1; last_rd = -1; rd_gaps = 0;
    first_v = -1; last_v = -1; v_gaps = 0; n_rx = 0; exp_d = 8'h00;
    @(posedge clk); #1;
    m_ready[k] = 1'b1;
    for (int i = 0; i < 16; i++) push_word(k, 8'(i));
    #1;
    for (int c = 0; c < 40; c++) begin
      if (rd_en[k]) begin
        n_rd++;
        if (first_rd < 0) first_rd = c;
        if (last_rd >= 0 && c != last_rd + 1) rd_gaps++;
        last_rd = c;
      end
      if (m_valid[k]) begin
        n_cmp++;
        if (m_data[k] !== exp_d) begin n_bad++; $display("FAIL full_data L=%0d: got %0h expected %0h", k+1, m_data[k], exp_d); end
        if (first_v < 0) first_v = c;
        if (last_v >= 0 && c != last_v + 1) v_gaps++;
        last_v = c;
        exp_d++;
        n_rx++;
      end
      @(posedge clk); #2;
    end
    n_cmp++;
    if (n_rd !== 16) begin n_bad++; $display("FAIL full_rd_count L=%0d: got %0d expected 16", k+1, n_rd); end
    n_cmp++;
    if (rd_gaps !== 0) begin n_bad++; $display("FAIL full_rd_gaps L=%0d: got %0d expected 0", k+1, rd_gaps); end
    n_cmp++;
    if (first_v - first_rd !== k + 2) begin n_bad++; $display("FAIL full_latency L=%0d: got %0d expected %0d", k+1, first_v - first_rd, k+2); end
    n_cmp++;
    if (n_rx !== 16) begin n_bad++; $display("FAIL full_rx_count L=%0d: got %0d expected 16", k+1, n_rx); end
    n_cmp++;
    if (v_gaps !== 0) begin n_bad++; $display("FAIL full_valid_gaps L=%0d: got %0d expected 0", k+1, v_gaps); end
    n_cmp++;
    if (m_valid[k] !== 1'b0) begin n_bad++; $display("FAIL full_idle L=%0d: got %0b expected 0", k+1, m_valid[k]); end
    m_ready[k] = 1'b0;
  endtask

  task automatic test_backpressure(input int k);
    int n_rd, n_rx;
    logic [7:0] exp_d;
    n_rd = 0; n_rx = 0; exp_d = 8'h10;
    @(posedge clk); #1;
    m_ready[k] = 1'b0;
    for (int i = 0; i < 8; i++) push_word(k, 8'(8'h10 + i));
    #1;
    for (int c = 0; c < 12; c++) begin
      if (rd_en[k]) n_rd++;
      if (m_valid[k]) begin
        n_cmp++;
        if (m_data[k] !== 8'h10) begin n_bad++; $display("FAIL bp_hold L=%0d: got %0h expected 10", k+1, m_data[k]); end
      end
      @(posedge clk); #2;
    end
    n_cmp++;
    if (n_rd !== k + 2) begin n_bad++; $display("FAIL bp_issues L=%0d: got %0d expected %0d", k+1, n_rd, k+2); end
    n_cmp++;
    if (buf_level[k] !== 2'(k + 2)) begin n_bad++; $display("FAIL bp_level L=%0d: got %0d expected %0d", k+1, buf_level[k], k+2); end
    n_cmp++;
    if (rd_en[k] !== 1'b0) begin n_bad++; $display("FAIL bp_rd_en L=%0d: got %0b expected 0", k+1, rd_en[k]); end
    n_cmp++;
    if (m_valid[k] !== 1'b1) begin n_bad++; $display("FAIL bp_valid L=%0d: got %0b expected 1", k+1, m_valid[k]); end
    @(posedge clk); #1;
    m_ready[k] = 1'b1;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (m_valid[k]) begin
        n_cmp++;
        if (m_data[k] !== exp_d) begin n_bad++; $display("FAIL bp_drain_data L=%0d: got %0h expected %0h", k+1, m_data[k], exp_d); end
        exp_d++;
        n_rx++;
      end
      @(posedge clk); #2;
    end
    n_cmp++;
    if (n_rx !== 8) begin n_bad++; $display("FAIL bp_drain_count L=%0d: got %0d expected 8", k+1, n_rx); end
    n_cmp++;
    if (m_valid[k] !== 1'b0) begin n_bad++; $display("FAIL bp_idle L=%0d: got %0b expected 0", k+1, m_valid[k]); end
    m_ready[k] = 1'b0;
  endtask

  task automatic test_random(input int k);
    int n_wr, n_rx, cyc, base, bad_issue;
    n_wr = 0; n_rx = 0; cyc = 0; bad_issue = 0;
    base = fwr[k];
    while (n_rx < 1000 && cyc < 8000) begin
      @(posedge clk); #1;
      if (n_wr < 1000 && $urandom_range(1, 0) == 1) begin
        push_word(k, 8'($urandom));
        n_wr++;
      end
      m_ready[k] = 1'($urandom_range(1, 0));
      #1;
      if (rd_en[k] && rd_empty[k]) bad_issue++;
      if (m_valid[k]) begin
        n_cmp++;
        if (m_data[k] !== fmem[k][base + n_rx]) begin
          n_bad++;
          $display("FAIL rand_data L=%0d word %0d: got %0h expected %0h", k+1, n_rx, m_data[k], fmem[k][base + n_rx]);
        end
        if (m_ready[k]) n_rx++;
      end
      cyc++;
    end
    n_cmp++;
    if (n_rx !== 1000) begin n_bad++; $display("FAIL rand_count L=%0d: got %0d expected 1000 (cycle budget)", k+1, n_rx); end
    n_cmp++;
    if (bad_issue !== 0) begin n_bad++; $display("FAIL rand_rd_en_on_empty L=%0d: got %0d expected 0", k+1, bad_issue); end
    n_cmp++;
    if (viol[k] !== 0) begin n_bad++; $display("FAIL model_read_on_empty L=%0d: got %0d expected 0", k+1, viol[k]); end
    @(posedge clk); #1;
    m_ready[k] = 1'b0;
  endtask

  task automatic test_single(input int k);
    int n_rx;
    n_rx = 0;
    @(posedge clk); #1;
    m_ready[k] = 1'b1;
    push_word(k, 8'hA5);
    #1;
    for (int c = 0; c < 10; c++) begin
      if (m_valid[k]) begin
        n_cmp++;
        if (m_data[k] !== 8'hA5) begin n_bad++; $display("FAIL single_data L=%0d: got %0h expected a5", k+1, m_data[k]); end
        n_rx++;
      end
      @(posedge clk); #2;
    end
    n_cmp++;
    if (n_rx !== 1) begin n_bad++; $display("FAIL single_count L=%0d: got %0d expected 1", k+1, n_rx); end
    n_cmp++;
    if (buf_level[k] !== 2'd0) begin n_bad++; $display("FAIL single_level L=%0d: got %0d expected 0", k+1, buf_level[k]); end
    m_ready[k] = 1'b0;
  endtask

  task automatic test_flush(input int k);
    int n_rx;
    logic [7:0] exp_d;
    n_rx = 0;
    exp_d = 8'(8'h50 + k + 2);
    @(posedge clk); #1;
    m_ready[k] = 1'b0;
    for (int i = 0; i < 8; i++) push_word(k, 8'(8'h50 + i));
    #1;
    repeat (k + 2) begin @(posedge clk); #2; end
    n_cmp++;
    if (buf_level[k] !== 2'd1) begin n_bad++; $display("FAIL flush_pre_level L=%0d: got %0d expected 1", k+1, buf_level[k]); end
    n_cmp++;
    if (m_data[k] !== 8'h50) begin n_bad++; $display("FAIL flush_pre_data L=%0d: got %0h expected 50", k+1, m_data[k]); end
    flush[k] = 1'b1;
    #1;
    n_cmp++;
    if (rd_en[k] !== 1'b0) begin n_bad++; $display("FAIL flush_rd_en L=%0d: got %0b expected 0", k+1, rd_en[k]); end
    @(posedge clk); #1;
    flush[k]   = 1'b0;
    m_ready[k] = 1'b1;
    #1;
    n_cmp++;
    if (m_valid[k] !== 1'b0) begin n_bad++; $display("FAIL flush_valid L=%0d: got %0b expected 0", k+1, m_valid[k]); end
    n_cmp++;
    if (buf_level[k] !== 2'd0) begin n_bad++; $display("FAIL flush_level L=%0d: got %0d expected 0", k+1, buf_level[k]); end
    for (int c = 0; c < 30; c++) begin
      if (m_valid[k]) begin
        n_cmp++;
        if (m_data[k] !== exp_d) begin n_bad++; $display("FAIL flush_after_data L=%0d: got %0h expected %0h", k+1, m_data[k], exp_d); end
        exp_d++;
        n_rx++;
      end
      @(posedge clk); #2;
    end
    n_cmp++;
    if (n_rx !== 6 - k) begin n_bad++; $display("FAIL flush_after_count L=%0d: got %0d expected %0d", k+1, n_rx, 6-k); end
    m_ready[k] = 1'b0;
  endtask

  task automatic test_reset_mid(input int k);
    int n_rd, n_rx;
    logic [7:0] exp_d;
    n_rd = 0; n_rx = 0; exp_d = 8'h60;
    @(posedge clk); #1;
    m_ready[k] = 1'b1;
    for (int i = 0; i < 16; i++) push_word(k, 8'(8'h60 + i));
    #1;
    for (int c = 0; c < 5; c++) begin
      if (rd_en[k]) n_rd++;
      if (m_valid[k]) begin
        n_cmp++;
        if (m_data[k] !== exp_d) begin n_bad++; $display("FAIL mid_pre_data L=%0d: got %0h expected %0h", k+1, m_data[k], exp_d); end
        exp_d++;
      end
      @(posedge clk); #2;
    end
    #1;
    rst[k] = 1'b1;
    #1;
    n_cmp++;
    if (n_rd !== 5) begin n_bad++; $display("FAIL mid_issues L=%0d: got %0d expected 5", k+1, n_rd); end
    n_cmp++;
    if (m_valid[k] !== 1'b0) begin n_bad++; $display("FAIL mid_valid L=%0d: got %0b expected 0", k+1, m_valid[k]); end
    n_cmp++;
    if (buf_level[k] !== 2'd0) begin n_bad++; $display("FAIL mid_level L=%0d: got %0d expected 0", k+1, buf_level[k]); end
    n_cmp++;
    if (rd_en[k] !== 1'b0) begin n_bad++; $display("FAIL mid_rd_en L=%0d: got %0b expected 0", k+1, rd_en[k]); end
    n_cmp++;
    if (m_data[k] !== 8'h00) begin n_bad++; $display("FAIL mid_data L=%0d: got %0h expected 00", k+1, m_data[k]); end
    repeat (2) @(posedge clk);
    #1;
    rst[k] = 1'b0;
    #1;
    exp_d = 8'h65;
    for (int c = 0; c < 30; c++) begin
      if (m_valid[k]) begin
        n_cmp++;
        if (m_data[k] !== exp_d) begin n_bad++; $display("FAIL mid_restart_data L=%0d: got %0h expected %0h", k+1, m_data[k], exp_d); end
        exp_d++;
        n_rx++;
      end
      @(posedge clk); #2;
    end
    n_cmp++;
    if (n_rx !== 11) begin n_bad++; $display("FAIL mid_restart_count L=%0d: got %0d expected 11", k+1, n_rx); end
    n_cmp++;
    if (m_valid[k] !== 1'b0) begin n_bad++; $display("FAIL mid_idle L=%0d: got %0b expected 0", k+1, m_valid[k]); end
    m_ready[k] = 1'b0;
  endtask

  initial begin
    rst     = 2'b11;
    flush   = 2'b00;
    m_ready = 2'b00;
    test_reset();
    for (int k = 0; k < 2; k++) begin
      test_full_rate(k);
      test_backpressure(k);
      test_random(k);
      test_single(k);
      test_flush(k);
      test_reset_mid(k);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
